sc_speed_ticker: RTL and testbench
==================================

// Module: sc_speed_ticker
// PURPOSE
//  Upstream stage of the SC_COUNTER road/distance counter. Converts player accelerate/brake buttons
//  into a speed level, then emits a one-cycle active-low count tick at a speed-dependent rate.
//  The tick drives the counter's count_InLow input directly.
//  A crash input forces a timed stop.
// PARAMETERS
//  TICK_DATAWIDTH  24          width of prescaler and hold timers
//  SPEED_LEVELS    8           speed levels 0..SPEED_LEVELS-1; 0 = stopped
//  BASE_PERIOD     6_250_000   tick period (clocks) at speed 1
//  PERIOD_STEP     750_000     period reduction per level above 1
//  ACCEL_HOLD      12_500_000  clocks accel must be held per +1 level
//  BRAKE_HOLD      6_250_000   clocks brake must be held per -1 level
//  CRASH_HOLD      50_000_000  clocks of forced stop after crash
//  Constraint: BASE_PERIOD > (SPEED_LEVELS-2)*PERIOD_STEP + 1; all HOLDs >= 1
// PORTS
//  SC_SPEEDTICK_CLOCK_50       in   1                      system clock, 50 MHz
//  SC_SPEEDTICK_RESET_InHigh   in   1                      reset, synchronous, active-high
//  SC_SPEEDTICK_accel_InLow    in   1                      accelerate button, active-low, pre-debounced
//  SC_SPEEDTICK_brake_InLow    in   1                      brake button, active-low, pre-debounced
//  SC_SPEEDTICK_crash_InHigh   in   1                      collision pulse/level from collision logic
//  SC_SPEEDTICK_tick_OutLow    out  1                      one-cycle low pulse -> SC_COUNTER count_InLow
//  SC_SPEEDTICK_speed_OutBUS   out  clog2(SPEED_LEVELS)    current speed level
//  SC_SPEEDTICK_crashed_OutHigh out 1                      high while in CRASHED
// BEHAVIOUR
//  Reset (sync, checked first): state=STOPPED, speed=0, prescaler=0, all timers=0,
//   tick_OutLow=1, crashed_OutHigh=0. Outputs take these values on the edge where reset is sampled high.
//  All outputs are registered.
//  FSM: STOPPED (speed==0), RUNNING (speed>0), CRASHED.
//   STOPPED->RUNNING when speed increments 0->1.
//   RUNNING->STOPPED when speed decrements to 0.
//   any->CRASHED when crash_InHigh is sampled high; CRASHED->STOPPED when the crash timer expires.
//  Priority per cycle: reset > crash > brake > accel > coast.
//  Accel (accel low, brake high, not CRASHED): accel timer increments each cycle.
//   On the ACCEL_HOLD-th consecutive low sample: speed+1 (saturates at SPEED_LEVELS-1) and the timer clears.
//   Release clears the timer.
//  Brake (brake low, not CRASHED): same scheme with BRAKE_HOLD; speed-1 saturating at 0.
//   Brake wins when both are low; the accel timer clears.
//  Coast (neither low): speed holds, both timers clear.
//  Period(speed) = BASE_PERIOD - (speed-1)*PERIOD_STEP for speed>=1.
//   Computed with TICK_DATAWIDTH-bit unsigned arithmetic; no overflow given the constraint.
//  Prescaler in RUNNING: counts 0..Period-1.
//   When prescaler >= Period-1: tick_OutLow=0 for exactly that next cycle and the prescaler wraps to 0.
//   Otherwise tick_OutLow=1.
//   Using >= means a speed-up mid-count never skips a tick: it fires on the next edge.
//  Tick latency: first tick is low on cycle Period after speed becomes 1; ticks are spaced exactly Period cycles.
//  STOPPED: prescaler held at 0, tick_OutLow=1.
//  Crash: on the next edge speed=0, prescaler=0, tick_OutLow=1, crashed=1, crash timer=CRASH_HOLD-1.
//   Buttons are ignored.
//   The timer counts down; at 0 the block goes to STOPPED and crashed=0 on that edge.
//   A crash sampled while in CRASHED reloads the timer.
//   A crash sampled high on the same edge that the timer reaches 0 keeps CRASHED and reloads the timer.
//  Reset mid-operation: immediate return to reset values; no partial tick is emitted.
// STRUCTURE
//  Package sc_speed_pkg:
//   - state localparams STOPPED=2'd0, RUNNING=2'd1, CRASHED=2'd2
//   - function period_of(speed) returning the period value
//   - width helper for the speed bus
//  Sub-module sc_hold_timer (enable, clear, HOLD parameter -> done pulse), instanced twice: accel and brake.
//  Prescaler and crash timer are inline in the top.
// TESTING  (sim params: BASE_PERIOD=10 PERIOD_STEP=1 SPEED_LEVELS=4 ACCEL_HOLD=4 BRAKE_HOLD=2 CRASH_HOLD=6)
//  1 Reset 3 cycles, buttons high for 50 cycles -> tick=1 throughout, speed=0, crashed=0.
//  2 accel low 4 cycles then release -> speed=1 after the 4th edge.
//    Ticks are single-cycle lows 10 cycles apart; the first comes 10 cycles after speed=1.
//  3 accel held 16 cycles -> speed 1,2,3 at edges 4,8,12 and stays at 3 (saturate); tick spacing 8.
//    Speed-up while prescaler=8 with new period 8 -> tick on the next edge.
//  4 From speed 3, accel and brake both low -> speed 2,1,0 at edges 2,4,6.
//    Ticks stop and state=STOPPED; accel timer stays 0.
//  5 Speed 2, prescaler=4, crash pulse 1 cycle -> next edge speed=0, crashed=1, tick=1 for 6 cycles.
//    accel low during CRASHED has no effect; crashed=0 at expiry.
//    Second crash at timer=2 extends by a full 6 cycles.
//  6 Speed 3, prescaler=5, reset 1 cycle -> next edge speed=0, prescaler=0, tick=1.
//    No tick in the following 20 cycles.

Source files
------------

// File: rtl/sc_speed_ticker_pkg.sv
// Shared types and helpers for the speed ticker: FSM states, speed bus width, tick period.
package sc_speed_pkg;

    typedef enum logic [1:0] {
        STOPPED = 2'd0,
        RUNNING = 2'd1,
        CRASHED = 2'd2
    } state_t;

    function automatic int speed_width(input int unsigned levels);
        return (levels > 2) ? $clog2(levels) : 1;
    endfunction

    // Period in clocks for a given speed; speed 0 never ticks, so it just returns the base.
    function automatic int unsigned period_of(input int unsigned speed,
                                              input int unsigned base,
                                              input int unsigned step);
        if (speed == 0) return base;
        return base - (speed - 1) * step;
    endfunction

endpackage

// File: rtl/sc_speed_ticker_if.sv
// Button inputs and tick/speed/crash outputs of the speed ticker.
interface sc_speed_ticker_if #(parameter int SPEED_W = 3);
    logic               accel_InLow;
    logic               brake_InLow;
    logic               crash_InHigh;
    logic               tick_OutLow;
    logic [SPEED_W-1:0] speed_OutBUS;
    logic               crashed_OutHigh;

    modport master (
        output accel_InLow, brake_InLow, crash_InHigh,
        input  tick_OutLow, speed_OutBUS, crashed_OutHigh
    );

    modport slave (
        input  accel_InLow, brake_InLow, crash_InHigh,
        output tick_OutLow, speed_OutBUS, crashed_OutHigh
    );
endinterface

// File: rtl/sc_hold_timer.sv
// Counts consecutive enabled cycles; pulses o_done combinationally on the HOLD-th one and restarts.
module sc_hold_timer #(
    parameter int          TW   = 24,
    parameter int unsigned HOLD = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_done
);
    localparam logic [TW-1:0] LAST = TW'(HOLD - 1);

    logic [TW-1:0] r_cnt;
    logic          w_hit;

    assign w_hit  = i_en && !i_clr && (r_cnt == LAST);
    assign o_done = w_hit;

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_cnt <= '0;
        else if (!i_en || i_clr || w_hit)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + TW'(1);
    end
endmodule

// File: rtl/sc_speed_ticker.sv
// Button-driven speed level with a speed-dependent active-low count tick and a timed crash stop.
//   state   | meaning
//   STOPPED | speed 0, prescaler held, no ticks
//   RUNNING | speed > 0, prescaler paces ticks
//   CRASHED | forced stop until the crash timer expires
module sc_speed_ticker
    import sc_speed_pkg::*;
#(
    parameter int          TICK_DATAWIDTH = 24,
    parameter int unsigned SPEED_LEVELS   = 8,
    parameter int unsigned BASE_PERIOD    = 6_250_000,
    parameter int unsigned PERIOD_STEP    = 750_000,
    parameter int unsigned ACCEL_HOLD     = 12_500_000,
    parameter int unsigned BRAKE_HOLD     = 6_250_000,
    parameter int unsigned CRASH_HOLD     = 50_000_000
) (
    input  logic              SC_SPEEDTICK_CLOCK_50,
    input  logic              SC_SPEEDTICK_RESET_InHigh,
    sc_speed_ticker_if.slave  io_bus
);
    localparam int SPEED_W = speed_width(SPEED_LEVELS);
    localparam int TW      = TICK_DATAWIDTH;
    // Crash hold outgrows the tick width at default settings, so it gets its own width.
    localparam int CW      = (CRASH_HOLD > 1) ? $clog2(CRASH_HOLD) : 1;
    localparam logic [SPEED_W-1:0] SPEED_MAX = SPEED_W'(SPEED_LEVELS - 1);

    state_t             r_state, w_state_n;
    logic [SPEED_W-1:0] r_speed, w_speed_n;
    logic [TW-1:0]      r_presc, w_presc_n;
    logic [CW-1:0]      r_crash_cnt, w_crash_cnt_n;
    logic               r_tick, w_tick_n;
    logic               r_crashed;
    logic [TW-1:0]      w_period;
    logic               w_frozen, w_accel_done, w_brake_done;

    assign w_frozen = io_bus.crash_InHigh || (r_state == CRASHED);
    assign w_period = TW'(period_of(32'(r_speed), BASE_PERIOD, PERIOD_STEP));

    sc_hold_timer #(.TW(TW), .HOLD(ACCEL_HOLD)) u_accel_timer (
        .i_clk  (SC_SPEEDTICK_CLOCK_50),
        .i_rst  (SC_SPEEDTICK_RESET_InHigh),
        .i_en   (!io_bus.accel_InLow && io_bus.brake_InLow),
        .i_clr  (w_frozen),
        .o_done (w_accel_done)
    );

    sc_hold_timer #(.TW(TW), .HOLD(BRAKE_HOLD)) u_brake_timer (
        .i_clk  (SC_SPEEDTICK_CLOCK_50),
        .i_rst  (SC_SPEEDTICK_RESET_InHigh),
        .i_en   (!io_bus.brake_InLow),
        .i_clr  (w_frozen),
        .o_done (w_brake_done)
    );

    always_ff @(posedge SC_SPEEDTICK_CLOCK_50) begin
        if (SC_SPEEDTICK_RESET_InHigh) begin
            r_state     <= STOPPED;
            r_speed     <= '0;
            r_presc     <= '0;
            r_crash_cnt <= '0;
            r_tick      <= 1'b1;
            r_crashed   <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_speed     <= w_speed_n;
            r_presc     <= w_presc_n;
            r_crash_cnt <= w_crash_cnt_n;
            r_tick      <= w_tick_n;
            r_crashed   <= (w_state_n == CRASHED);
        end
    end

    always_comb begin
        w_state_n     = r_state;
        w_speed_n     = r_speed;
        w_presc_n     = '0;
        w_crash_cnt_n = r_crash_cnt;
        w_tick_n      = 1'b1;

        if (io_bus.crash_InHigh) begin
            w_state_n     = CRASHED;
            w_speed_n     = '0;
            w_crash_cnt_n = CW'(CRASH_HOLD - 1);
        end else if (r_state == CRASHED) begin
            if (r_crash_cnt == '0)
                w_state_n = STOPPED;
            else
                w_crash_cnt_n = r_crash_cnt - CW'(1);
        end else begin
            // >= rather than == so a mid-count speed-up fires on the next edge instead of wrapping.
            if (r_state == RUNNING) begin
                if (r_presc >= w_period - TW'(1))
                    w_tick_n = 1'b0;
                else
                    w_presc_n = r_presc + TW'(1);
            end
            if (w_brake_done && r_speed != '0)
                w_speed_n = r_speed - SPEED_W'(1);
            else if (w_accel_done && r_speed != SPEED_MAX)
                w_speed_n = r_speed + SPEED_W'(1);
            if (w_speed_n == '0) begin
                w_state_n = STOPPED;
                w_presc_n = '0;
            end else begin
                w_state_n = RUNNING;
            end
        end
    end

    assign io_bus.tick_OutLow     = r_tick;
    assign io_bus.speed_OutBUS    = r_speed;
    assign io_bus.crashed_OutHigh = r_crashed;
endmodule

// File: tb/tb_sc_speed_ticker.sv
// Segment-table bench for sc_speed_ticker with a cycle-level reference model feeding a scoreboard.
module tb_sc_speed_ticker;
    localparam int BASE = 10;
    localparam int STEP = 1;
    localparam int LEVELS = 4;
    localparam int AH = 4;
    localparam int BH = 2;
    localparam int CH = 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sc_speed_ticker_if #(.SPEED_W(2)) bus ();

    sc_speed_ticker #(
        .TICK_DATAWIDTH (24),
        .SPEED_LEVELS   (LEVELS),
        .BASE_PERIOD    (BASE),
        .PERIOD_STEP    (STEP),
        .ACCEL_HOLD     (AH),
        .BRAKE_HOLD     (BH),
        .CRASH_HOLD     (CH)
    ) dut (
        .SC_SPEEDTICK_CLOCK_50     (clk),
        .SC_SPEEDTICK_RESET_InHigh (rst),
        .io_bus                    (bus)
    );

    typedef struct {
        bit    r;
        bit    a_l;
        bit    b_l;
        bit    c;
        int    n;
        int    exp_speed;
        int    exp_crashed;
        int    exp_ticks;
        string name;
    } seg_t;

    typedef struct {
        int tick;
        int speed;
        int crashed;
    } exp_t;

    exp_t sb_q[$];
    seg_t segs[$];
    int   errors = 0;
    int   checks = 0;

    int m_speed, m_presc, m_acnt, m_bcnt, m_cleft, m_tick, m_crashed;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit a_l, input bit b_l, input bit c);
        int per;
        if (r) begin
            m_speed = 0; m_presc = 0; m_acnt = 0; m_bcnt = 0;
            m_cleft = 0; m_tick = 1; m_crashed = 0;
        end else if (c) begin
            m_crashed = 1; m_cleft = CH - 1; m_speed = 0; m_presc = 0;
            m_tick = 1; m_acnt = 0; m_bcnt = 0;
        end else if (m_crashed == 1) begin
            m_tick = 1; m_acnt = 0; m_bcnt = 0;
            if (m_cleft == 0) m_crashed = 0;
            else m_cleft--;
        end else begin
            m_tick = 1;
            if (m_speed > 0) begin
                per = BASE - (m_speed - 1) * STEP;
                if (m_presc >= per - 1) begin
                    m_tick = 0;
                    m_presc = 0;
                end else begin
                    m_presc++;
                end
            end
            if (!b_l) begin
                m_acnt = 0;
                m_bcnt++;
                if (m_bcnt == BH) begin
                    m_bcnt = 0;
                    if (m_speed > 0) m_speed--;
                end
            end else if (!a_l) begin
                m_bcnt = 0;
                m_acnt++;
                if (m_acnt == AH) begin
                    m_acnt = 0;
                    if (m_speed < LEVELS - 1) m_speed++;
                end
            end else begin
                m_acnt = 0;
                m_bcnt = 0;
            end
            if (m_speed == 0) m_presc = 0;
        end
        sb_q.push_back('{m_tick, m_speed, m_crashed});
    endtask

    task automatic run_seg(input seg_t s);
        exp_t e;
        int   ticks;
        ticks = 0;
        for (int i = 0; i < s.n; i++) begin
            rst              = s.r;
            bus.accel_InLow  = s.a_l;
            bus.brake_InLow  = s.b_l;
            bus.crash_InHigh = s.c;
            model_step(s.r, s.a_l, s.b_l, s.c);
            @(posedge clk);
            @(negedge clk);
            if (sb_q.size() == 0) begin
                chk({s.name, " scoreboard_empty"}, 0, 1);
            end else begin
                e = sb_q.pop_front();
                chk({s.name, " tick"}, int'(bus.tick_OutLow), e.tick);
                chk({s.name, " speed"}, int'(bus.speed_OutBUS), e.speed);
                chk({s.name, " crashed"}, int'(bus.crashed_OutHigh), e.crashed);
            end
            if (bus.tick_OutLow == 1'b0) ticks++;
        end
        chk({s.name, " end_speed"}, int'(bus.speed_OutBUS), s.exp_speed);
        chk({s.name, " end_crashed"}, int'(bus.crashed_OutHigh), s.exp_crashed);
        chk({s.name, " tick_count"}, ticks, s.exp_ticks);
    endtask

    function automatic seg_t mk(input bit r, input bit a_l, input bit b_l, input bit c, input int n,
                                input int sp, input int cr, input int tk, input string name);
        seg_t s;
        s.r = r; s.a_l = a_l; s.b_l = b_l; s.c = c; s.n = n;
        s.exp_speed = sp; s.exp_crashed = cr; s.exp_ticks = tk; s.name = name;
        return s;
    endfunction

    initial begin
        rst = 1'b1;
        bus.accel_InLow  = 1'b1;
        bus.brake_InLow  = 1'b1;
        bus.crash_InHigh = 1'b0;
        model_step(1'b1, 1'b1, 1'b1, 1'b0);
        void'(sb_q.pop_front());

        //            r  a  b  c   n  spd cr tk
        segs.push_back(mk(1, 1, 1, 0,  3, 0, 0, 0, "reset"));
        segs.push_back(mk(0, 1, 1, 0, 50, 0, 0, 0, "idle_stopped"));
        segs.push_back(mk(0, 0, 1, 0,  4, 1, 0, 0, "accel_to_1"));
        segs.push_back(mk(0, 1, 1, 0, 25, 1, 0, 2, "run_speed1"));
        segs.push_back(mk(0, 1, 0, 0,  2, 0, 0, 0, "brake_to_0"));
        segs.push_back(mk(0, 0, 1, 0, 16, 3, 0, 1, "accel_saturate"));
        segs.push_back(mk(0, 1, 1, 0, 20, 3, 0, 2, "run_speed3"));
        segs.push_back(mk(0, 0, 0, 0,  6, 0, 0, 1, "both_brake_wins"));
        segs.push_back(mk(0, 1, 1, 0, 20, 0, 0, 0, "idle_after_brake"));
        segs.push_back(mk(0, 0, 1, 0,  8, 2, 0, 0, "accel_to_2"));
        segs.push_back(mk(0, 1, 1, 1,  1, 0, 1, 0, "crash"));
        segs.push_back(mk(0, 0, 1, 0,  3, 0, 1, 0, "accel_in_crash"));
        segs.push_back(mk(0, 1, 1, 1,  1, 0, 1, 0, "crash_reload"));
        segs.push_back(mk(0, 1, 1, 0,  5, 0, 1, 0, "crash_hold"));
        segs.push_back(mk(0, 1, 1, 0,  1, 0, 0, 0, "crash_expire"));
        segs.push_back(mk(0, 1, 1, 0,  5, 0, 0, 0, "idle_after_crash"));
        segs.push_back(mk(0, 0, 1, 0, 12, 3, 0, 0, "accel_to_3"));
        segs.push_back(mk(0, 1, 1, 0,  6, 3, 0, 1, "run_to_presc5"));
        segs.push_back(mk(1, 1, 1, 0,  1, 0, 0, 0, "reset_mid_run"));
        segs.push_back(mk(0, 1, 1, 0, 20, 0, 0, 0, "idle_after_reset"));

        for (int i = 0; i < segs.size(); i++)
            run_seg(segs[i]);

        // Crash sampled on the very edge the crash timer reaches zero must stay crashed.
        run_seg(mk(0, 1, 1, 1, 1, 0, 1, 0, "crash2"));
        run_seg(mk(0, 1, 1, 0, 5, 0, 1, 0, "crash2_run_down"));
        run_seg(mk(0, 1, 1, 1, 1, 0, 1, 0, "crash_at_expiry"));
        run_seg(mk(0, 1, 1, 0, 5, 0, 1, 0, "crash_at_expiry_hold"));
        run_seg(mk(0, 1, 1, 0, 1, 0, 0, 0, "crash_at_expiry_exit"));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
